// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 driver: register addresses, state encodings
// and the power-up configuration words.
package max7219_pkg;

    localparam logic [3:0] REG_DIGIT0    = 4'h1;
    localparam logic [3:0] REG_DECODE    = 4'h9;
    localparam logic [3:0] REG_INTENSITY = 4'hA;
    localparam logic [3:0] REG_SCANLIM   = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
    localparam logic [3:0] REG_TEST      = 4'hF;

    typedef enum logic [2:0] {
        W_IDLE,
        W_LOAD,
        W_SHIFT_LO,
        W_SHIFT_HI,
        W_LATCH
    } word_state_t;

    typedef enum logic [2:0] {
        SEQ_INIT0,
        SEQ_INIT1,
        SEQ_INIT2,
        SEQ_INIT3,
        SEQ_INIT4,
        SEQ_DISP
    } seq_state_t;

    // Configuration word sent at each init step; the display step never uses it.
    function automatic logic [15:0] init_word(input seq_state_t step, input logic [3:0] intensity);
        logic [15:0] w;
        case (step)
            SEQ_INIT0: w = {4'h0, REG_SHUTDOWN,  8'h01};
            SEQ_INIT1: w = {4'h0, REG_DECODE,    8'h00};
            SEQ_INIT2: w = {4'h0, REG_SCANLIM,   8'h07};
            SEQ_INIT3: w = {4'h0, REG_INTENSITY, 4'h0, intensity};
            SEQ_INIT4: w = {4'h0, REG_TEST,      8'h00};
            default:   w = 16'h0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/max7219_shift.sv
// 16-bit MSB-first serializer producing DIN/CLK/LOAD with CLK_DIV-cycle phases.
// A word starts while start is high; done marks the last LATCH cycle.
module max7219_shift
    import max7219_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] word,
    output logic        din,
    output logic        sclk,
    output logic        load,
    output logic        busy,
    output logic        done,
    output logic        done_soon
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] DIV_PRE  = 8'(CLK_DIV - 2);

    word_state_t state, state_d;
    logic [7:0]  cnt, cnt_d;
    logic [3:0]  bit_cnt, bit_cnt_d;
    logic [15:0] sr, sr_d;
    logic        phase_end;

    assign phase_end = (cnt == DIV_LAST);
    assign done      = (state == W_LATCH) && phase_end;
    assign done_soon = (state == W_LATCH) && (cnt == DIV_PRE);

    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        state_d   = state;
        cnt_d     = cnt;
        bit_cnt_d = bit_cnt;
        sr_d      = sr;
        case (state)
            W_IDLE: begin
                if (start) state_d = W_LOAD;
            end
            W_LOAD: begin
                sr_d      = word;
                bit_cnt_d = 4'd0;
                cnt_d     = 8'd0;
                state_d   = W_SHIFT_LO;
            end
            W_SHIFT_LO: begin
                if (phase_end) begin
                    cnt_d   = 8'd0;
                    state_d = W_SHIFT_HI;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            W_SHIFT_HI: begin
                if (phase_end) begin
                    cnt_d     = 8'd0;
                    sr_d      = {sr[14:0], 1'b0};
                    bit_cnt_d = bit_cnt + 4'd1;
                    state_d   = (bit_cnt == 4'd15) ? W_LATCH : W_SHIFT_LO;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            W_LATCH: begin
                if (phase_end) begin
                    cnt_d   = 8'd0;
                    state_d = start ? W_LOAD : W_IDLE;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    // Pin outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= W_IDLE;
            cnt     <= 8'd0;
            bit_cnt <= 4'd0;
            sr      <= 16'h0000;
            din     <= 1'b0;
            sclk    <= 1'b0;
            load    <= 1'b1;
            busy    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            state   <= state_d;
            cnt     <= cnt_d;
            bit_cnt <= bit_cnt_d;
            sr      <= sr_d;
            sclk    <= (state_d == W_SHIFT_HI);
            load    <= !((state_d == W_SHIFT_LO) || (state_d == W_SHIFT_HI));
            busy    <= (state_d != W_IDLE);
            if ((state_d == W_SHIFT_LO) && (state != W_SHIFT_LO))
                din <= sr_d[15];
        end
    end

endmodule

// File: rtl/max7219_driver.sv
// MAX7219 driver top: sends the configuration words once per reset, then refreshes
// digits 1..8 forever from the column byte returned by the image mux.
module max7219_driver
    import max7219_pkg::*;
#(
    parameter int         CLK_DIV   = 4,
    parameter logic [3:0] INTENSITY = 4'hF
) (
    input  logic       max_CLOCK_50,
    input  logic       max_RESET_InHigh,
    input  logic       max_enable,
    input  logic [7:0] max_data_in,
    output logic [2:0] max_select_add,
    output logic       max_din,
    output logic       max_sclk,
    output logic       max_load,
    output logic       max_busy,
    output logic       max_frame_done
);

    seq_state_t  seq, seq_d;
    logic [2:0]  digit, digit_d;
    logic [2:0]  select_d;
    logic [15:0] word;
    logic        done;
    logic        done_soon;

    // Display data goes straight into the serializer, so it is captured in the LOAD cycle.
    assign word = (seq == SEQ_DISP)
                ? {4'h0, {1'b0, max_select_add} + REG_DIGIT0, max_data_in}
                : init_word(seq, INTENSITY);

    assign max_frame_done = done && (seq == SEQ_DISP) && (digit == 3'd7);

    always_comb begin
        seq_d    = seq;
        digit_d  = digit;
        select_d = max_select_add;
        if (done) begin
            if (seq == SEQ_DISP) digit_d = digit + 3'd1;
            else                 seq_d   = seq_state_t'(seq + 3'd1);
        end
        // Moving the select one cycle before the last LATCH cycle gives the mux a full cycle to settle.
        if (done_soon && (seq == SEQ_DISP))
            select_d = digit + 3'd1;
    end

    always_ff @(posedge max_CLOCK_50 or posedge max_RESET_InHigh) begin
        if (max_RESET_InHigh) begin
            seq            <= SEQ_INIT0;
            digit          <= 3'd0;
            max_select_add <= 3'd0;
        end else begin
            seq            <= seq_d;
            digit          <= digit_d;
            max_select_add <= select_d;
        end
    end

    max7219_shift #(
        .CLK_DIV (CLK_DIV)
    ) u_shift (
        .clk       (max_CLOCK_50),
        .rst       (max_RESET_InHigh),
        .start     (max_enable),
        .word      (word),
        .din       (max_din),
        .sclk      (max_sclk),
        .load      (max_load),
        .busy      (max_busy),
        .done      (done),
        .done_soon (done_soon)
    );

endmodule

// File: tb/tb_max7219_driver.sv
// Bench for max7219_driver: decodes the DIN/CLK/LOAD stream and compares every word and
// timing property with a word-index model of the init/refresh sequence.
module tb_max7219_driver;

    localparam int DIV_A  = 4;
    localparam int DIV_B  = 2;
    localparam int WLEN_A = 1 + 33 * DIV_A;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       en       = 1'b0;
    logic       mux_rand = 1'b0;
    logic [7:0] rnd_data = 8'h00;
    logic [7:0] data_a, data_b;
    logic [2:0] sel_a, sel_b;
    logic       din_a, sclk_a, load_a, busy_a, fd_a;
    logic       din_b, sclk_b, load_b, busy_b, fd_b;

    int          n_checks   = 0;
    int          n_fail     = 0;
    int          n_model    = 0;
    int          words_seen = 0;
    int          bits       = 0;
    int          fd_count   = 0;
    logic        in_word    = 1'b0;
    logic [15:0] last_word  = 16'h0000;

    assign data_a = mux_rand ? rnd_data : (8'hA0 | {5'd0, sel_a});
    assign data_b = 8'hA0 | {5'd0, sel_b};

    max7219_driver #(.CLK_DIV(DIV_A), .INTENSITY(4'hF)) dut_a (
        .max_CLOCK_50     (clk),
        .max_RESET_InHigh (rst),
        .max_enable       (en),
        .max_data_in      (data_a),
        .max_select_add   (sel_a),
        .max_din          (din_a),
        .max_sclk         (sclk_a),
        .max_load         (load_a),
        .max_busy         (busy_a),
        .max_frame_done   (fd_a)
    );

    max7219_driver #(.CLK_DIV(DIV_B), .INTENSITY(4'hF)) dut_b (
        .max_CLOCK_50     (clk),
        .max_RESET_InHigh (rst),
        .max_enable       (en),
        .max_data_in      (data_b),
        .max_select_add   (sel_b),
        .max_din          (din_b),
        .max_sclk         (sclk_b),
        .max_load         (load_b),
        .max_busy         (busy_b),
        .max_frame_done   (fd_b)
    );

    initial forever #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Word number idx since reset: five config words, then digits 1..8 repeating.
    function automatic logic [15:0] model_word(input int idx, input logic [7:0] data);
        logic [15:0] init_tab [0:4];
        init_tab = '{16'h0C01, 16'h0900, 16'h0B07, 16'h0A0F, 16'h0F00};
        if (idx < 5) return init_tab[idx];
        return {4'h0, 4'((idx - 5) % 8 + 1), data};
    endfunction

    function automatic int model_digit(input int idx);
        return (idx < 5) ? 0 : (idx - 5) % 8;
    endfunction

    // Random column data, held on the cycle the select moves.
    initial begin : mux_drive
        logic [2:0] last_sel;
        last_sel = 3'd0;
        forever begin
            @(negedge clk);
            #1;
            if (sel_a == last_sel) rnd_data = 8'($urandom);
            last_sel = sel_a;
        end
    end

    initial begin : mon_a
        logic        pl, ps, pd, cont, cap_rand;
        logic [2:0]  psel, p2sel, cap_sel, cap_sel_prev;
        logic [7:0]  cap_data;
        logic [15:0] sh, exp;
        int          cyc, fall_cyc, rise_cyc, fd_exp, bad;
        pl = 1'b1; ps = 1'b0; pd = 1'b0; cont = 1'b0; cap_rand = 1'b0;
        psel = 3'd0; p2sel = 3'd0; cap_sel = 3'd0; cap_sel_prev = 3'd0;
        cap_data = 8'h00; sh = 16'h0000; exp = 16'h0000;
        cyc = 0; fall_cyc = 0; rise_cyc = 0; fd_exp = -1; bad = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                n_model = 0; in_word = 1'b0; cont = 1'b0; fd_exp = -1;
                pl = 1'b1; ps = 1'b0; pd = 1'b0; psel = 3'd0; p2sel = 3'd0;
            end else begin
                if (!en) cont = 1'b0;
                if (pl && !load_a) begin
                    if (cont) check("word_len", cyc - fall_cyc, WLEN_A);
                    cont = 1'b1; fall_cyc = cyc; in_word = 1'b1; bits = 0; sh = 16'h0000; bad = 0;
                    cap_data = data_a; cap_rand = mux_rand; cap_sel = psel; cap_sel_prev = p2sel;
                end
                if (in_word && !load_a) begin
                    if (sclk_a && !ps) begin
                        sh = {sh[14:0], din_a};
                        bits++;
                        rise_cyc = cyc;
                    end
                    if ((din_a != pd) && (cyc != fall_cyc) && !(ps && !sclk_a)) bad++;
                end
                if (in_word && !pl && load_a) begin
                    exp = model_word(n_model, cap_rand ? cap_data : (8'hA0 | 8'(model_digit(n_model))));
                    check("word", sh, exp);
                    check("sclk_rises", bits, 16);
                    check("load_rise_delay", cyc - rise_cyc, DIV_A);
                    check("din_change_on_fall", bad, 0);
                    check("select", cap_sel, model_digit(n_model));
                    check("select_setup", cap_sel_prev, model_digit(n_model));
                    check("busy_latch", busy_a, 1);
                    if (n_model >= 5 && model_digit(n_model) == 7) fd_exp = cyc + DIV_A - 1;
                    last_word = sh;
                    n_model++;
                    words_seen++;
                    in_word = 1'b0;
                end
                if (fd_a || (cyc == fd_exp)) check("frame_done", fd_a, cyc == fd_exp);
                if (fd_a) fd_count++;
                p2sel = psel; psel = sel_a; pl = load_a; ps = sclk_a; pd = din_a;
            end
        end
    end

    // Second instance at CLK_DIV = 2: phase lengths, word length and the first two words.
    initial begin : mon_b
        logic        pl, ps;
        logic [15:0] sh;
        logic [15:0] exp_b [0:1];
        int          run, nw, bad, fall0, fall1, c;
        exp_b = '{16'h0C01, 16'h0900};
        @(negedge rst);
        pl = 1'b1; ps = 1'b0; sh = 16'h0000;
        run = 0; nw = 0; bad = 0; fall0 = 0; fall1 = 0; c = 0;
        while (nw < 2 && c < 400) begin
            @(negedge clk);
            c++;
            if (pl && !load_b) begin
                if (nw == 0) fall0 = c;
                else         fall1 = c;
                sh  = 16'h0000;
                run = 1;
            end else if (ps != sclk_b) begin
                if (run != DIV_B) bad++;
                run = 1;
            end else begin
                run++;
            end
            if (!load_b && sclk_b && !ps) sh = {sh[14:0], din_b};
            if (!pl && load_b) begin
                check("b_word", sh, exp_b[nw]);
                check("b_busy", busy_b, 1);
                check("b_frame_done", fd_b, 0);
                nw++;
            end
            pl = load_b; ps = sclk_b;
        end
        check("b_words", nw, 2);
        check("b_phase_len", bad, 0);
        check("b_word_len", fall1 - fall0, 1 + 33 * DIV_B);
    end

    initial begin : main
        int c, ws;
        repeat (4) @(negedge clk);
        check("rst_din", din_a, 0);
        check("rst_sclk", sclk_a, 0);
        check("rst_load", load_a, 1);
        check("rst_select", sel_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_frame_done", fd_a, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_load", load_a, 1);
        check("idle_busy", busy_a, 0);

        // Init words, one full frame, and the wrap back to digit 1.
        en = 1'b1;
        c = 0;
        while (n_model < 14 && c < 3000) begin @(negedge clk); c++; end
        check("frame1_progress", n_model, 14);
        check("frame_done_count", fd_count, 1);
        check("wrap_word", last_word, 16'h01A0);

        // Random column data; drop enable during bit 5 of the addr-4 word.
        #3 mux_rand = 1'b1;
        c = 0;
        while (!(in_word && n_model == 16 && bits == 5) && c < 1000) begin @(negedge clk); c++; end
        check("reach_digit3_bit5", n_model, 16);
        en = 1'b0;
        ws = words_seen;
        c = 0;
        while (words_seen == ws && c < 200) begin @(negedge clk); c++; end
        check("paused_word_addr", last_word[11:8], 4);
        repeat (DIV_A + 2) @(negedge clk);
        check("pause_load", load_a, 1);
        check("pause_busy", busy_a, 0);
        check("pause_sclk", sclk_a, 0);
        ws = words_seen;
        repeat (200) @(negedge clk);
        check("pause_no_words", words_seen, ws);
        check("pause_load_held", load_a, 1);
        en = 1'b1;
        c = 0;
        while (words_seen == ws && c < 400) begin @(negedge clk); c++; end
        check("resume_addr", last_word[11:8], 5);

        // Fresh init, then reset during bit 9 of the second config word.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        c = 0;
        while (!(in_word && n_model == 1 && bits == 9) && c < 600) begin @(negedge clk); c++; end
        check("reach_init1_bit9", n_model, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_din", din_a, 0);
        check("midrst_sclk", sclk_a, 0);
        check("midrst_load", load_a, 1);
        check("midrst_select", sel_a, 0);
        check("midrst_busy", busy_a, 0);
        check("midrst_frame_done", fd_a, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        c = 0;
        while (n_model < 3 && c < 800) begin @(negedge clk); c++; end
        check("restart_progress", n_model, 3);
        check("restart_third_word", last_word, 16'h0B07);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
